router_fsm: RTL and testbench
=============================

# router_fsm

Packet-sequencing controller for the 1x3 router. It watches the incoming header and payload handshake, selects the destination FIFO by the 2-bit header address, and stalls while a FIFO is busy or full. It drives the datapath phase strobes (`detect_add`, `write_en_reg`, `lfd_state`, `ld_state`, `laf_state`, `full_state`, `rst_int_reg`) consumed by the register block and the synchronizer. It also asserts `busy` back to the packet source.

## Interface
- `WAIT_TIMEOUT`, 64: cycles allowed in WAIT_TILL_EMPTY before the packet is dropped; must be ≥2. Used only with the macro.
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high reset.
- `pkt_valid` in 1: source has a valid header or payload byte this cycle.
- `data_in` in 2: header address bits (`data_in[1:0]` of the header byte).
- `parity_done` in 1: register block has captured the parity byte.
- `low_pkt_valid` in 1: register block saw `pkt_valid` drop while full.
- `fifo_full` in 1: the selected FIFO is full (from the synchronizer).
- `fifo_empty_0`, `fifo_empty_1`, `fifo_empty_2` in 1 each: per-FIFO empty flags.
- `soft_reset_0`, `soft_reset_1`, `soft_reset_2` in 1 each: per-FIFO timeout resets from the synchronizer.
- `detect_add`, `lfd_state`, `ld_state`, `laf_state`, `full_state` out 1 each: state decodes.
- `write_en_reg` out 1: datapath write strobe.
- `rst_int_reg` out 1: clears the register-block internal parity.
- `busy` out 1: stall to the source.
- `drop_pkt` out 1: one-cycle drop pulse.

## Operation
- Eight states: DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, FIFO_FULL_STATE, LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR, WAIT_TILL_EMPTY.
- The state register is binary encoded.
- `addr_q[1:0]` is captured from `data_in` whenever the state is DECODE_ADDRESS and `pkt_valid` is high.

State transitions:
- **DECODE_ADDRESS**
  - `pkt_valid` with address k∈{0,1,2} and `fifo_empty_k` high → LOAD_FIRST_DATA.
  - `pkt_valid` with address k and `fifo_empty_k` low → WAIT_TILL_EMPTY.
  - Address 2'b11 or no `pkt_valid` → stay.
- **LOAD_FIRST_DATA** → LOAD_DATA, unconditionally.
- **LOAD_DATA**
  - `fifo_full` → FIFO_FULL_STATE.
  - Otherwise, `pkt_valid` low → LOAD_PARITY.
  - Otherwise → stay.
- **FIFO_FULL_STATE**
  - `fifo_full` low → LOAD_AFTER_FULL.
  - Otherwise → stay.
- **LOAD_AFTER_FULL** (priority order)
  - `parity_done` → DECODE_ADDRESS.
  - Else `low_pkt_valid` → LOAD_PARITY.
  - Else → LOAD_DATA.
- **LOAD_PARITY** → CHECK_PARITY_ERROR.
- **CHECK_PARITY_ERROR**
  - `fifo_full` → FIFO_FULL_STATE.
  - Otherwise → DECODE_ADDRESS.
- **WAIT_TILL_EMPTY**
  - `fifo_empty_[addr_q]` high → LOAD_FIRST_DATA.
  - Otherwise → stay (see Configuration).

Global priority rules:
- `reset` overrides everything.
- Next priority: if `soft_reset_[addr_q]` is high in any state other than DECODE_ADDRESS → DECODE_ADDRESS.
- A `soft_reset` for a non-selected FIFO is ignored.

Moore outputs, decoded from the state register:
- `detect_add` = DECODE_ADDRESS.
- `lfd_state` = LOAD_FIRST_DATA.
- `ld_state` = LOAD_DATA.
- `full_state` = FIFO_FULL_STATE.
- `laf_state` = LOAD_AFTER_FULL.
- `rst_int_reg` = CHECK_PARITY_ERROR.
- `write_en_reg` = LOAD_DATA | LOAD_AFTER_FULL | LOAD_PARITY.
- `busy` = every state except DECODE_ADDRESS and LOAD_DATA.

## Timing
- **Reset values:**
  - State = DECODE_ADDRESS, so `detect_add`=1.
  - All other outputs = 0.
  - `addr_q`=0.
  - Timer = 0.
- **Latency:** next state is registered, so outputs change one cycle after the condition that causes the transition. There are no combinational paths from inputs to outputs.
- **Header latency:** `pkt_valid` high at edge N in DECODE_ADDRESS with an empty target → `lfd_state`=1 in cycle N+1 → `ld_state`=1 in cycle N+2.
- **Same-cycle full and pkt_valid drop:** in LOAD_DATA, `fifo_full` wins over `pkt_valid` falling.
- **Reset mid-packet:** `reset` asserted in any state returns to DECODE_ADDRESS on the next edge; the packet is lost silently and `drop_pkt` stays 0.

## Configuration
- **`ROUTER_FSM_WAIT_TIMEOUT_EN` defined:**
  - A counter runs while in WAIT_TILL_EMPTY and clears on leaving that state.
  - When the count reaches `WAIT_TIMEOUT-1` with `fifo_empty_[addr_q]` still low, the next state is DECODE_ADDRESS and `drop_pkt` is registered high for exactly one cycle.
  - Empty arriving on that same cycle wins: the FSM goes to LOAD_FIRST_DATA and no drop occurs.
- **Macro undefined:**
  - No counter is built.
  - `drop_pkt` is tied to 0.
  - WAIT_TILL_EMPTY waits indefinitely; only `soft_reset_[addr_q]` or `reset` can exit it.

## Structure
- **Package `router_pkg`** holds:
  - The state localparams/typedef.
  - Address codes `ADDR_0`/`ADDR_1`/`ADDR_2`/`ADDR_INVALID`.
  - The default `WAIT_TIMEOUT`.
- **Sub-module `router_wait_timer`** holds the timeout counter and its terminal-count compare. It is instantiated only under the macro.

## Test plan
- **Reset:** `reset`=1 for 2 cycles → `detect_add`=1, `busy`=0, all other outputs 0.
- **Address 01, target empty:** header addr 01, `fifo_empty_1`=1, `pkt_valid` held 5 cycles then dropped → states LFD, LD×4, LOAD_PARITY, CHECK_PARITY_ERROR, DECODE_ADDRESS. `write_en_reg` is high during LD and LOAD_PARITY; `rst_int_reg` pulses for 1 cycle.
- **Full mid-packet:** `fifo_full`=1 for 3 cycles during LD → `full_state`=1 and `busy`=1 for 3 cycles, then `laf_state` for 1 cycle, then return to LD.
- **Address 10, target not empty:** header addr 10 with `fifo_empty_2`=0 → WAIT_TILL_EMPTY (`busy`=1). Raising `fifo_empty_2` → LFD on the next cycle.
- **Invalid address and soft reset:**
  - Header addr 11 → FSM stays in DECODE_ADDRESS.
  - `soft_reset_0` while in LD for addr 0 → DECODE_ADDRESS next cycle.
  - `soft_reset_1` in the same situation → no effect.
- **Macro defined, `WAIT_TIMEOUT`=8:** target never empties → `drop_pkt` is a single pulse 8 cycles after entering WAIT_TILL_EMPTY, followed by DECODE_ADDRESS.

Source files
------------

// File: rtl/router_pkg.sv
// router_pkg: shared definitions for the 1x3 router packet-sequencing FSM.
//   - Binary state encodings (state_t + localparam constants).
//   - Header address codes ADDR_0/ADDR_1/ADDR_2/ADDR_INVALID.
//   - DEFAULT_WAIT_TIMEOUT: default drop timeout in cycles, used when
//     ROUTER_FSM_WAIT_TIMEOUT_EN is defined.
//   - select_flag(): picks the per-FIFO flag addressed by a 2-bit address.
package router_pkg;

  typedef logic [2:0] state_t;

  localparam state_t DECODE_ADDRESS     = 3'd0;
  localparam state_t LOAD_FIRST_DATA    = 3'd1;
  localparam state_t LOAD_DATA          = 3'd2;
  localparam state_t FIFO_FULL_STATE    = 3'd3;
  localparam state_t LOAD_AFTER_FULL    = 3'd4;
  localparam state_t LOAD_PARITY        = 3'd5;
  localparam state_t CHECK_PARITY_ERROR = 3'd6;
  localparam state_t WAIT_TILL_EMPTY    = 3'd7;

  localparam logic [1:0] ADDR_0       = 2'b00;
  localparam logic [1:0] ADDR_1       = 2'b01;
  localparam logic [1:0] ADDR_2       = 2'b10;
  localparam logic [1:0] ADDR_INVALID = 2'b11;

  localparam int DEFAULT_WAIT_TIMEOUT = 64;

  // The invalid address selects no FIFO, so its flag always reads 0.
  function automatic logic select_flag(input logic [2:0] flags, input logic [1:0] addr);
    case (addr)
      ADDR_0:  return flags[0];
      ADDR_1:  return flags[1];
      ADDR_2:  return flags[2];
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/router_wait_timer.sv
// router_wait_timer: cycle counter for the WAIT_TILL_EMPTY drop timeout.
// Instantiated by router_fsm only when ROUTER_FSM_WAIT_TIMEOUT_EN is defined.
// Ports:
//   clk     in  : rising-edge clock
//   reset   in  : synchronous active-high reset
//   run     in  : FSM remains in WAIT_TILL_EMPTY next cycle; low clears count
//   expired out : count has reached WAIT_TIMEOUT-1
module router_wait_timer
  import router_pkg::*;
#(
  parameter int WAIT_TIMEOUT = DEFAULT_WAIT_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic expired
);

  localparam int CNT_W = $clog2(WAIT_TIMEOUT);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (run) begin
      count <= count + CNT_W'(1);
    end else begin
      count <= '0;
    end
  end

  assign expired = (count == CNT_W'(WAIT_TIMEOUT - 1));

endmodule

// File: rtl/router_fsm.sv
// router_fsm: packet-sequencing controller for the 1x3 router.
// Selects the destination FIFO from the header address, stalls on busy/full
// FIFOs and drives the datapath phase strobes. All outputs are decoded from
// registered state, so there is no combinational input-to-output path.
// Optional feature: define ROUTER_FSM_WAIT_TIMEOUT_EN to drop a packet that
// waits WAIT_TIMEOUT cycles for a non-empty FIFO (drop_pkt pulses once);
// otherwise drop_pkt is tied low and WAIT_TILL_EMPTY waits indefinitely.
// Ports:
//   clk, reset (sync, active-high)
//   pkt_valid, data_in[1:0]          : header/payload handshake and address
//   parity_done, low_pkt_valid       : register-block status
//   fifo_full                        : selected FIFO full
//   fifo_empty_0..2, soft_reset_0..2 : per-FIFO empty flags / timeout resets
//   detect_add, lfd_state, ld_state, laf_state, full_state : state decodes
//   write_en_reg, rst_int_reg, busy, drop_pkt             : control outputs
module router_fsm
  import router_pkg::*;
#(
  parameter int WAIT_TIMEOUT = DEFAULT_WAIT_TIMEOUT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  input  logic       fifo_full,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       write_en_reg,
  output logic       rst_int_reg,
  output logic       busy,
  output logic       drop_pkt
);

  if (WAIT_TIMEOUT < 2) begin : g_bad_timeout
    $error("router_fsm: WAIT_TIMEOUT must be at least 2");
  end

  state_t     state;
  state_t     next_state;
  logic [1:0] addr_q;
  logic [2:0] empty_vec;
  logic [2:0] soft_vec;
  logic       empty_sel;
  logic       soft_sel;
  logic       timeout;

  assign empty_vec = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
  assign soft_vec  = {soft_reset_2, soft_reset_1, soft_reset_0};
  assign empty_sel = select_flag(empty_vec, addr_q);
  assign soft_sel  = select_flag(soft_vec, addr_q);

  always_comb begin
    next_state = state;
    case (state)
      DECODE_ADDRESS: begin
        if (pkt_valid && (data_in != ADDR_INVALID)) begin
          next_state = select_flag(empty_vec, data_in) ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        end
      end
      LOAD_FIRST_DATA: next_state = LOAD_DATA;
      LOAD_DATA: begin
        // A full FIFO takes precedence over the end of the payload.
        if (fifo_full)       next_state = FIFO_FULL_STATE;
        else if (!pkt_valid) next_state = LOAD_PARITY;
      end
      FIFO_FULL_STATE: begin
        if (!fifo_full) next_state = LOAD_AFTER_FULL;
      end
      LOAD_AFTER_FULL: begin
        if (parity_done)        next_state = DECODE_ADDRESS;
        else if (low_pkt_valid) next_state = LOAD_PARITY;
        else                    next_state = LOAD_DATA;
      end
      LOAD_PARITY: next_state = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: next_state = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      WAIT_TILL_EMPTY: begin
        // Empty arriving on the terminal-count cycle still wins.
        if (empty_sel)    next_state = LOAD_FIRST_DATA;
        else if (timeout) next_state = DECODE_ADDRESS;
      end
      default: next_state = DECODE_ADDRESS;
    endcase
    // Only the selected FIFO's timeout reset can abort a packet in flight.
    if ((state != DECODE_ADDRESS) && soft_sel) next_state = DECODE_ADDRESS;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= DECODE_ADDRESS;
      addr_q <= ADDR_0;
    end else begin
      state <= next_state;
      if ((state == DECODE_ADDRESS) && pkt_valid) addr_q <= data_in;
    end
  end

`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
  logic timer_run;
  logic drop_q;

  // Keep counting only while the FSM stays put; any exit clears the count.
  assign timer_run = (state == WAIT_TILL_EMPTY) && (next_state == WAIT_TILL_EMPTY);

  router_wait_timer #(
    .WAIT_TIMEOUT(WAIT_TIMEOUT)
  ) u_wait_timer (
    .clk    (clk),
    .reset  (reset),
    .run    (timer_run),
    .expired(timeout)
  );

  // A soft reset on the same cycle aborts the packet instead of dropping it.
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_q <= 1'b0;
    end else begin
      drop_q <= (state == WAIT_TILL_EMPTY) && timeout && !empty_sel && !soft_sel;
    end
  end

  assign drop_pkt = drop_q;
`else
  assign timeout  = 1'b0;
  assign drop_pkt = 1'b0;
`endif

  assign detect_add   = (state == DECODE_ADDRESS);
  assign lfd_state    = (state == LOAD_FIRST_DATA);
  assign ld_state     = (state == LOAD_DATA);
  assign full_state   = (state == FIFO_FULL_STATE);
  assign laf_state    = (state == LOAD_AFTER_FULL);
  assign rst_int_reg  = (state == CHECK_PARITY_ERROR);
  assign write_en_reg = (state == LOAD_DATA) || (state == LOAD_AFTER_FULL) ||
                        (state == LOAD_PARITY);
  assign busy         = !((state == DECODE_ADDRESS) || (state == LOAD_DATA));

endmodule

// File: tb/tb_router_fsm.sv
// tb_router_fsm: directed + randomized bench for router_fsm with a
// behavioural phase model. Define ROUTER_FSM_WAIT_TIMEOUT_EN to also build
// and exercise the drop timeout (WAIT_TIMEOUT = 8).
module tb_router_fsm;

`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 64;
`endif

  logic       clk = 1'b0;
  logic       reset, pkt_valid, parity_done, low_pkt_valid, fifo_full;
  logic [1:0] data_in;
  logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state;
  logic       write_en_reg, rst_int_reg, busy, drop_pkt;

  router_fsm #(.WAIT_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid), .fifo_full(fifo_full),
    .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1), .fifo_empty_2(fifo_empty_2),
    .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1), .soft_reset_2(soft_reset_2),
    .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state), .write_en_reg(write_en_reg),
    .rst_int_reg(rst_int_reg), .busy(busy), .drop_pkt(drop_pkt)
  );

  always #5 clk = ~clk;

  typedef enum {P_DEC, P_LFD, P_LD, P_FULL, P_LAF, P_LP, P_CPE, P_WAIT} phase_e;

  phase_e ph;
  int     maddr;
  int     waited;
  bit     mdrop;
  int     compared   = 0;
  int     mismatched = 0;

  logic [7:0] outs;
  assign outs = {detect_add, lfd_state, ld_state, full_state, laf_state,
                 rst_int_reg, write_en_reg, busy};

  // Expected strobes per phase: {detect,lfd,ld,full,laf,rst_int,wen,busy}
  function automatic logic [7:0] exp_outs(phase_e p);
    case (p)
      P_DEC:   return 8'b1000_0000;
      P_LFD:   return 8'b0100_0001;
      P_LD:    return 8'b0010_0010;
      P_FULL:  return 8'b0001_0001;
      P_LAF:   return 8'b0000_1011;
      P_LP:    return 8'b0000_0011;
      P_CPE:   return 8'b0000_0101;
      default: return 8'b0000_0001;
    endcase
  endfunction

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    bit [2:0] emp;
    bit [2:0] srs;
    phase_e   n;
    int       na;
    bit       nd;
    emp = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
    srs = {soft_reset_2, soft_reset_1, soft_reset_0};
    if (reset) begin
      ph = P_DEC; maddr = 0; waited = 0; mdrop = 0;
      return;
    end
    n = ph; na = maddr; nd = 0;
    case (ph)
      P_DEC: if (pkt_valid) begin
        na = int'(data_in);
        if (na != 3) n = emp[na] ? P_LFD : P_WAIT;
      end
      P_LFD:  n = P_LD;
      P_LD:   if (fifo_full) n = P_FULL; else if (!pkt_valid) n = P_LP;
      P_FULL: if (!fifo_full) n = P_LAF;
      P_LAF:  n = parity_done ? P_DEC : (low_pkt_valid ? P_LP : P_LD);
      P_LP:   n = P_CPE;
      P_CPE:  n = fifo_full ? P_FULL : P_DEC;
      P_WAIT: begin
        if (emp[maddr]) n = P_LFD;
`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
        else if (waited + 1 == TO) begin n = P_DEC; nd = 1; end
`endif
      end
      default: n = P_DEC;
    endcase
    if (ph != P_DEC && maddr < 3 && srs[maddr]) begin n = P_DEC; nd = 0; end
    // waited = number of completed cycles spent in the current wait episode
    if (n == P_WAIT && ph == P_WAIT) waited = waited + 1;
    else waited = 0;
    ph = n; maddr = na; mdrop = nd;
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("outs_vs_model", outs, exp_outs(ph));
    chk("drop_vs_model", {7'b0, drop_pkt}, {7'b0, mdrop});
  endtask

  task automatic idle_inputs();
    reset = 0; pkt_valid = 0; data_in = 0; parity_done = 0; low_pkt_valid = 0;
    fifo_full = 0; fifo_empty_0 = 1; fifo_empty_1 = 1; fifo_empty_2 = 1;
    soft_reset_0 = 0; soft_reset_1 = 0; soft_reset_2 = 0;
  endtask

  initial begin
    ph = P_DEC; maddr = 0; waited = 0; mdrop = 0;
    idle_inputs();
    reset = 1;
    tick(); tick();
    chk("reset_outs", outs, 8'b1000_0000);
    chk("reset_drop", {7'b0, drop_pkt}, 8'h00);
    reset = 0;

    // Address 01, empty target, 5-cycle payload handshake
    pkt_valid = 1; data_in = 2'b01;
    tick(); chk("a1_lfd", {7'b0, lfd_state}, 8'h01);
    tick(); chk("a1_ld", {6'b0, ld_state, write_en_reg}, 8'h03);
    repeat (3) tick();
    chk("a1_ld4", {7'b0, ld_state}, 8'h01);
    pkt_valid = 0;
    tick(); chk("a1_lp", {6'b0, write_en_reg, busy}, 8'h03);
    tick(); chk("a1_cpe", {7'b0, rst_int_reg}, 8'h01);
    tick(); chk("a1_dec", {6'b0, detect_add, rst_int_reg}, 8'h02);

    // Full mid-packet on address 00
    pkt_valid = 1; data_in = 2'b00;
    tick(); tick();
    fifo_full = 1;
    for (int i = 0; i < 3; i++) begin
      tick(); chk("full_busy", {6'b0, full_state, busy}, 8'h03);
    end
    fifo_full = 0;
    tick(); chk("laf", {7'b0, laf_state}, 8'h01);
    tick(); chk("back_ld", {7'b0, ld_state}, 8'h01);
    pkt_valid = 0;
    tick(); tick(); tick();

    // Address 10, target not empty
    fifo_empty_2 = 0; pkt_valid = 1; data_in = 2'b10;
    tick(); chk("wait_busy", {7'b0, busy}, 8'h01);
    pkt_valid = 0;
    tick(); tick();
    fifo_empty_2 = 1;
    tick(); chk("wait_lfd", {7'b0, lfd_state}, 8'h01);
    tick(); tick(); tick(); tick();

    // Invalid address, then soft resets during LD for address 00
    pkt_valid = 1; data_in = 2'b11;
    tick(); chk("inv_addr", {7'b0, detect_add}, 8'h01);
    data_in = 2'b00;
    tick(); tick();
    soft_reset_1 = 1;
    tick(); chk("sr1_ignored", {7'b0, ld_state}, 8'h01);
    soft_reset_1 = 0; soft_reset_0 = 1;
    tick(); chk("sr0_abort", {7'b0, detect_add}, 8'h01);
    soft_reset_0 = 0; pkt_valid = 0;
    tick();

    // Reset mid-packet
    pkt_valid = 1; data_in = 2'b01;
    tick(); tick();
    reset = 1;
    tick(); chk("rst_mid", {6'b0, detect_add, drop_pkt}, 8'h02);
    reset = 0; pkt_valid = 0;
    tick();

`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
    // Target never empties: drop pulse 8 cycles after entering the wait
    fifo_empty_2 = 0; pkt_valid = 1; data_in = 2'b10;
    tick();
    pkt_valid = 0;
    for (int i = 1; i <= TO; i++) begin
      tick();
      if (i < TO) chk("to_waiting", {6'b0, busy, drop_pkt}, 8'h02);
    end
    chk("to_drop", {6'b0, detect_add, drop_pkt}, 8'h03);
    tick(); chk("to_drop_once", {7'b0, drop_pkt}, 8'h00);
    fifo_empty_2 = 1;
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      reset         = ($urandom_range(0, 63) == 0);
      pkt_valid     = ($urandom_range(0, 3) != 0);
      data_in       = 2'($urandom_range(0, 3));
      parity_done   = ($urandom_range(0, 3) == 0);
      low_pkt_valid = ($urandom_range(0, 3) == 0);
      fifo_full     = ($urandom_range(0, 4) == 0);
      fifo_empty_0  = ($urandom_range(0, 5) != 0);
      fifo_empty_1  = ($urandom_range(0, 5) != 0);
      fifo_empty_2  = ($urandom_range(0, 15) == 0);
      soft_reset_0  = ($urandom_range(0, 19) == 0);
      soft_reset_1  = ($urandom_range(0, 19) == 0);
      soft_reset_2  = ($urandom_range(0, 39) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
